// File: rtl/rob_pkg.sv
// Shared types for the multi-port reorder buffer.
// Entry layout plus the branch resolution helper used at completion.
package rob_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int IDXW      = $clog2(ROB_DEPTH);
    localparam int XLEN      = 32;
    localparam int PREGW     = 6;

    typedef struct packed {
        logic             valid;
        logic             completed;
        logic             is_store;
        logic             is_branch;
        logic             pred_taken;
        logic             mispred;
        logic [PREGW-1:0] dest_preg;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  npc;
        logic [XLEN-1:0]  pred_pc;
        logic [XLEN-1:0]  recover_pc;
    } rob_entry_t;

    // Returns {mispred, recover_pc} for a completing entry.
    function automatic logic [XLEN:0] resolve(
        input rob_entry_t      e,
        input logic            taken,
        input logic [XLEN-1:0] tgt
    );
        logic [XLEN:0] r;
        r = '0;
        unique case (1'b1)
            e.is_branch && e.pred_taken && !taken:
                r = {1'b1, e.npc};
            e.is_branch && !e.pred_taken && taken:
                r = {1'b1, tgt};
            e.is_branch && e.pred_taken && taken
                && (tgt != e.pred_pc):
                r = {1'b1, tgt};
            default:
                r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Head-window retire scan: in-order prefix, store credit gating
// and flush selection from the oldest mispredicted retiring entry.
module rob_retire_sel
    import rob_pkg::*;
#(
    parameter int RW   = 3,
    parameter int CNTW = 6,
    parameter int CRW  = 2
) (
    input  logic [RW-1:0]           ent_valid,
    input  logic [RW-1:0]           ent_done,
    input  logic [RW-1:0]           ent_store,
    input  logic [RW-1:0]           ent_mispred,
    input  logic [RW-1:0][XLEN-1:0] ent_recover,
    input  logic [CNTW-1:0]         count,
    input  logic [CRW-1:0]          sq_credit,
    output logic [RW-1:0]           ret_valid,
    output logic [CRW-1:0]          ret_n,
    output logic                    flush,
    output logic [XLEN-1:0]         flush_pc
);

    always_comb begin
        logic [CRW:0] stores;
        logic         stop;
        ret_valid = '0;
        ret_n     = '0;
        flush     = 1'b0;
        flush_pc  = '0;
        stores    = '0;
        stop      = 1'b0;
        for (int j = 0; j < RW; j++) begin
            if (!stop) begin
                if (CNTW'(j) >= count
                    || !ent_valid[j] || !ent_done[j]) begin
                    stop = 1'b1;
                end else if (ent_store[j]
                    && stores >= {1'b0, sq_credit}) begin
                    stop = 1'b1;
                end else begin
                    ret_valid[j] = 1'b1;
                    ret_n  = ret_n + 1'b1;
                    stores = stores + (CRW+1)'(ent_store[j]);
                    // Younger lanes must not retire past a mispredict.
                    if (ent_mispred[j]) begin
                        flush    = 1'b1;
                        flush_pc = ent_recover[j];
                        stop     = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// Parametrised reorder buffer with independent dispatch, completion
// and retire widths, count-based occupancy and retire-time flush.
module rob_multiport
    import rob_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int DW    = 3,
    parameter int CW    = 3,
    parameter int RW    = 3,
    localparam int IW   = $clog2(DEPTH),
    localparam int CRW  = $clog2(RW + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DW-1:0]           disp_valid,
    input  rob_entry_t [DW-1:0]     disp_entry,
    output logic [DW-1:0]           disp_ready,
    output logic [DW-1:0][IW-1:0]   disp_idx,
    input  logic [CW-1:0]           cmp_valid,
    input  logic [CW-1:0][IW-1:0]   cmp_idx,
    input  logic [CW-1:0]           cmp_taken,
    input  logic [CW-1:0][XLEN-1:0] cmp_target,
    input  logic [CRW-1:0]          sq_credit,
    output logic [RW-1:0]           ret_valid,
    output rob_entry_t [RW-1:0]     ret_entry,
    output logic                    flush,
    output logic [XLEN-1:0]         flush_pc,
    output logic [IW:0]             count
);

    rob_entry_t q   [DEPTH];
    rob_entry_t q_n [DEPTH];

    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [IW:0]   free;
    logic [IW:0]   n_acc;
    logic [DW-1:0] acc;

    rob_entry_t [RW-1:0]     win;
    logic [RW-1:0]           w_valid;
    logic [RW-1:0]           w_done;
    logic [RW-1:0]           w_store;
    logic [RW-1:0]           w_mp;
    logic [RW-1:0][XLEN-1:0] w_rpc;
    logic [CRW-1:0]          ret_n;
    logic                    sel_flush;
    logic [XLEN-1:0]         sel_pc;
    logic                    unused_disp;

    // Payload status fields are overwritten on dispatch.
    assign unused_disp = ^disp_entry;

    // Registered count only: same-cycle retires free slots next cycle.
    assign free = (IW+1)'(DEPTH) - count;

    always_comb begin
        n_acc = '0;
        for (int i = 0; i < DW; i++) begin
            disp_ready[i] = (IW+1)'(i) < free;
            acc[i]        = disp_valid[i] & disp_ready[i];
            disp_idx[i]   = acc[i] ? tail + IW'(i) : '0;
            n_acc         = n_acc + (IW+1)'(acc[i]);
        end
    end

    always_comb begin
        for (int j = 0; j < RW; j++) begin
            win[j]     = q[head + IW'(j)];
            w_valid[j] = win[j].valid;
            w_done[j]  = win[j].completed;
            w_store[j] = win[j].is_store;
            w_mp[j]    = win[j].mispred;
            w_rpc[j]   = win[j].recover_pc;
        end
    end

    rob_retire_sel #(
        .RW   (RW),
        .CNTW (IW + 1),
        .CRW  (CRW)
    ) u_sel (
        .ent_valid   (w_valid),
        .ent_done    (w_done),
        .ent_store   (w_store),
        .ent_mispred (w_mp),
        .ent_recover (w_rpc),
        .count       (count),
        .sq_credit   (sq_credit),
        .ret_valid   (ret_valid),
        .ret_n       (ret_n),
        .flush       (sel_flush),
        .flush_pc    (sel_pc)
    );

    always_comb begin
        for (int j = 0; j < RW; j++) begin
            ret_entry[j] = ret_valid[j] ? win[j] : '0;
        end
    end

    assign flush    = sel_flush & ~reset;
    assign flush_pc = flush ? sel_pc : '0;

    always_comb begin
        logic [IW-1:0] wi;
        logic [XLEN:0] res;
        wi  = '0;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            q_n[i] = q[i];
        end
        for (int k = 0; k < DW; k++) begin
            if (acc[k]) begin
                wi                = tail + IW'(k);
                q_n[wi]            = disp_entry[k];
                q_n[wi].valid      = 1'b1;
                q_n[wi].completed  = 1'b0;
                q_n[wi].mispred    = 1'b0;
                q_n[wi].recover_pc = '0;
            end
        end
        for (int c = 0; c < CW; c++) begin
            if (cmp_valid[c] && q[cmp_idx[c]].valid) begin
                wi  = cmp_idx[c];
                res = resolve(q[wi], cmp_taken[c], cmp_target[c]);
                q_n[wi].completed  = 1'b1;
                q_n[wi].mispred    = res[XLEN];
                q_n[wi].recover_pc = res[XLEN-1:0];
            end
        end
        for (int j = 0; j < RW; j++) begin
            if (ret_valid[j]) begin
                q_n[head + IW'(j)] = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            head  <= head + IW'(ret_n);
            tail  <= tail + n_acc[IW-1:0];
            count <= count + n_acc - (IW+1)'(ret_n);
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= q_n[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert ((({1'b0, acc} + 1'b1) & {1'b0, acc}) == '0);
            for (int c = 0; c < CW; c++) begin
                if (cmp_valid[c]) begin
                    assert (q[cmp_idx[c]].valid);
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: table-driven fill/complete phase
// followed by hand sequences for stores, flush, wrap and reset.
module tb_rob_multiport;
    import rob_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [2:0]            disp_valid;
    rob_entry_t [2:0]      disp_entry;
    logic [2:0]            disp_ready;
    logic [2:0][4:0]       disp_idx;
    logic [2:0]            cmp_valid;
    logic [2:0][4:0]       cmp_idx;
    logic [2:0]            cmp_taken;
    logic [2:0][XLEN-1:0]  cmp_target;
    logic [1:0]            sq_credit;
    logic [2:0]            ret_valid;
    rob_entry_t [2:0]      ret_entry;
    logic                  flush;
    logic [XLEN-1:0]       flush_pc;
    logic [5:0]            count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    rob_multiport dut (
        .clock      (clock),
        .reset      (reset),
        .disp_valid (disp_valid),
        .disp_entry (disp_entry),
        .disp_ready (disp_ready),
        .disp_idx   (disp_idx),
        .cmp_valid  (cmp_valid),
        .cmp_idx    (cmp_idx),
        .cmp_taken  (cmp_taken),
        .cmp_target (cmp_target),
        .sq_credit  (sq_credit),
        .ret_valid  (ret_valid),
        .ret_entry  (ret_entry),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .count      (count)
    );

    typedef struct {
        logic [2:0] dv;
        logic       cv;
        logic [4:0] ci;
        logic [2:0] e_ready;
        logic [2:0] e_ret;
        logic [5:0] e_count;
        logic [4:0] e_base;
        logic [4:0] e_rbase;
    } vec_t;

    vec_t tbl [16];

    function automatic rob_entry_t mk(
        input logic       st,
        input logic       br,
        input logic       pt,
        input logic [5:0] d,
        input logic [31:0] npc,
        input logic [31:0] ppc
    );
        rob_entry_t e;
        e            = '0;
        e.is_store   = st;
        e.is_branch  = br;
        e.pred_taken = pt;
        e.dest_preg  = d;
        e.pc         = 32'h1000 + 32'(d) * 4;
        e.npc        = npc;
        e.pred_pc    = ppc;
        return e;
    endfunction

    function automatic vec_t row(
        input logic [2:0] dv, input logic cv, input logic [4:0] ci,
        input logic [2:0] er, input logic [2:0] et,
        input int ec, input int eb, input int erb
    );
        vec_t v;
        v.dv = dv; v.cv = cv; v.ci = ci;
        v.e_ready = er; v.e_ret = et;
        v.e_count = 6'(ec);
        v.e_base  = 5'(eb);
        v.e_rbase = 5'(erb);
        return v;
    endfunction

    task automatic check(
        input string nm,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        disp_valid = '0;
        disp_entry = '0;
        cmp_valid  = '0;
        cmp_idx    = '0;
        cmp_taken  = '0;
        cmp_target = '0;
        sq_credit  = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;

        for (int r = 0; r < 11; r++) begin
            tbl[r] = row(3'b111, 1'b0, 5'd0,
                         (r == 10) ? 3'b011 : 3'b111,
                         3'b000, 3 * r, 3 * r, 0);
        end
        tbl[11] = row(3'b000, 1'b1, 5'd2, 3'b000, 3'b000, 32, 0, 0);
        tbl[12] = row(3'b000, 1'b1, 5'd1, 3'b000, 3'b000, 32, 0, 0);
        tbl[13] = row(3'b000, 1'b1, 5'd0, 3'b000, 3'b000, 32, 0, 0);
        tbl[14] = row(3'b111, 1'b0, 5'd0, 3'b000, 3'b111, 32, 0, 0);
        tbl[15] = row(3'b000, 1'b0, 5'd0, 3'b111, 3'b000, 29, 0, 0);

        for (int r = 0; r < 16; r++) begin
            idle();
            disp_valid = tbl[r].dv;
            for (int k = 0; k < 3; k++) begin
                disp_entry[k] = mk(0, 0, 0, 6'(3 * r + k), 0, 0);
            end
            cmp_valid  = {2'b00, tbl[r].cv};
            cmp_idx[0] = tbl[r].ci;
            sq_credit  = 2'd3;
            #1;
            check($sformatf("r%0d ready", r), 64'(disp_ready), 64'(tbl[r].e_ready));
            check($sformatf("r%0d ret", r), 64'(ret_valid), 64'(tbl[r].e_ret));
            check($sformatf("r%0d count", r), 64'(count), 64'(tbl[r].e_count));
            check($sformatf("r%0d flush", r), 64'(flush), 64'd0);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("r%0d idx%0d", r, k), 64'(disp_idx[k]),
                      (tbl[r].dv[k] & tbl[r].e_ready[k])
                      ? 64'(5'(tbl[r].e_base + 5'(k))) : 64'd0);
                if (tbl[r].e_ret[k]) begin
                    check($sformatf("r%0d rdest%0d", r, k),
                          64'(ret_entry[k].dest_preg),
                          64'(tbl[r].e_rbase) + 64'(k));
                end
            end
            tick();
        end

        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;

        // Store credit gating
        idle();
        disp_valid = 3'b111;
        for (int k = 0; k < 3; k++) disp_entry[k] = mk(1, 0, 0, 6'(k), 0, 0);
        #1;
        check("st ready", 64'(disp_ready), 64'b111);
        for (int k = 0; k < 3; k++)
            check($sformatf("st idx%0d", k), 64'(disp_idx[k]), 64'(k));
        tick();

        idle();
        disp_valid    = 3'b001;
        disp_entry[0] = mk(0, 0, 0, 6'd3, 0, 0);
        cmp_valid     = 3'b111;
        for (int k = 0; k < 3; k++) cmp_idx[k] = 5'(k);
        #1;
        check("st cmp ret", 64'(ret_valid), 64'b000);
        check("st cmp count", 64'(count), 64'd3);
        tick();

        idle();
        sq_credit = 2'd1;
        #1;
        check("st c1 ret", 64'(ret_valid), 64'b001);
        check("st c1 dest", 64'(ret_entry[0].dest_preg), 64'd0);
        tick();

        idle();
        #1;
        check("st c0 ret", 64'(ret_valid), 64'b000);
        check("st c0 count", 64'(count), 64'd3);
        tick();

        idle();
        sq_credit  = 2'd2;
        cmp_valid  = 3'b001;
        cmp_idx[0] = 5'd3;
        #1;
        check("st c2 ret", 64'(ret_valid), 64'b011);
        check("st c2 dest0", 64'(ret_entry[0].dest_preg), 64'd1);
        check("st c2 dest1", 64'(ret_entry[1].dest_preg), 64'd2);
        tick();

        // Branch mispredict flush
        idle();
        disp_valid    = 3'b011;
        disp_entry[0] = mk(0, 0, 0, 6'd4, 0, 0);
        disp_entry[1] = mk(0, 1, 1, 6'd5, 32'h104, 32'h200);
        #1;
        check("br plain ret", 64'(ret_valid), 64'b001);
        check("br plain dest", 64'(ret_entry[0].dest_preg), 64'd3);
        check("br idx0", 64'(disp_idx[0]), 64'd4);
        check("br idx1", 64'(disp_idx[1]), 64'd5);
        tick();

        idle();
        cmp_valid     = 3'b011;
        cmp_idx[0]    = 5'd4;
        cmp_idx[1]    = 5'd5;
        cmp_target[1] = 32'h200;
        #1;
        check("br cmp ret", 64'(ret_valid), 64'b000);
        check("br cmp count", 64'(count), 64'd2);
        tick();

        idle();
        disp_valid = 3'b111;
        for (int k = 0; k < 3; k++) disp_entry[k] = mk(0, 0, 0, 6'(6 + k), 0, 0);
        #1;
        check("br ret", 64'(ret_valid), 64'b011);
        check("br dest1", 64'(ret_entry[1].dest_preg), 64'd5);
        check("br flush", 64'(flush), 64'd1);
        check("br flush_pc", 64'(flush_pc), 64'h104);
        tick();

        idle();
        disp_valid    = 3'b001;
        disp_entry[0] = mk(0, 0, 0, 6'd0, 0, 0);
        #1;
        check("post count", 64'(count), 64'd0);
        check("post ret", 64'(ret_valid), 64'b000);
        check("post flush", 64'(flush), 64'd0);
        check("post ready", 64'(disp_ready), 64'b111);
        check("post idx0", 64'(disp_idx[0]), 64'd0);
        tick();

        // Walk head/tail to 30, then wrap
        for (int c = 0; c < 10; c++) begin
            idle();
            disp_valid = (c < 9) ? 3'b111 : 3'b011;
            for (int k = 0; k < 3; k++)
                disp_entry[k] = mk(0, 0, 0, 6'(1 + 3 * c + k), 0, 0);
            #1;
            check($sformatf("fill%0d idx0", c), 64'(disp_idx[0]), 64'(1 + 3 * c));
            tick();
        end
        for (int c = 0; c < 11; c++) begin
            idle();
            if (c < 10) begin
                cmp_valid = 3'b111;
                for (int k = 0; k < 3; k++) cmp_idx[k] = 5'(3 * c + k);
            end
            #1;
            check($sformatf("drain%0d ret", c), 64'(ret_valid),
                  (c == 0) ? 64'b000 : 64'b111);
            check($sformatf("drain%0d count", c), 64'(count),
                  (c == 0) ? 64'd30 : 64'(30 - 3 * (c - 1)));
            tick();
        end

        idle();
        disp_valid = 3'b111;
        disp_entry[0] = mk(0, 0, 0, 6'd30, 0, 0);
        disp_entry[1] = mk(0, 0, 0, 6'd31, 0, 0);
        disp_entry[2] = mk(0, 0, 0, 6'd0, 0, 0);
        #1;
        check("wrap count0", 64'(count), 64'd0);
        check("wrap idx0", 64'(disp_idx[0]), 64'd30);
        check("wrap idx1", 64'(disp_idx[1]), 64'd31);
        check("wrap idx2", 64'(disp_idx[2]), 64'd0);
        tick();

        idle();
        cmp_valid  = 3'b111;
        cmp_idx[0] = 5'd30;
        cmp_idx[1] = 5'd31;
        cmp_idx[2] = 5'd0;
        #1;
        check("wrap cmp ret", 64'(ret_valid), 64'b000);
        tick();

        idle();
        disp_valid = 3'b111;
        for (int k = 0; k < 3; k++) disp_entry[k] = mk(0, 0, 0, 6'(1 + k), 0, 0);
        #1;
        check("wrap ret", 64'(ret_valid), 64'b111);
        check("wrap rdest0", 64'(ret_entry[0].dest_preg), 64'd30);
        check("wrap rdest1", 64'(ret_entry[1].dest_preg), 64'd31);
        check("wrap rdest2", 64'(ret_entry[2].dest_preg), 64'd0);
        for (int k = 0; k < 3; k++)
            check($sformatf("wrap2 idx%0d", k), 64'(disp_idx[k]), 64'(1 + k));
        tick();

        idle();
        #1;
        check("wrap count", 64'(count), 64'd3);
        tick();

        // Reset with 10 entries in flight
        for (int c = 0; c < 3; c++) begin
            idle();
            disp_valid = (c < 2) ? 3'b111 : 3'b001;
            tick();
        end
        idle();
        #1;
        check("inflight count", 64'(count), 64'd10);
        reset = 1'b1;
        #1;
        check("rst flush", 64'(flush), 64'd0);
        tick();
        reset = 1'b0;
        disp_valid = 3'b001;
        #1;
        check("rst count", 64'(count), 64'd0);
        check("rst ret", 64'(ret_valid), 64'b000);
        check("rst flush2", 64'(flush), 64'd0);
        check("rst ready", 64'(disp_ready), 64'b111);
        check("rst idx0", 64'(disp_idx[0]), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
